reg_cmd_engine: RTL



---
 rtl/reg_cmd_pkg.sv | 40 ++++
 rtl/reg_cmd_engine_alu.sv | 49 ++++
 rtl/reg_cmd_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_cmd_pkg
// Description : Shared opcodes, FSM state encoding, ALU operation select and
//               the bytes-per-word helper for the register command engine.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_cmd_pkg;

  // Command opcodes carried in bits [3:0] of the first byte of a command
  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_MOV_IMM = 4'd1;
  localparam logic [3:0] OP_GET     = 4'd2;
  localparam logic [3:0] OP_ACC     = 4'd3;
  localparam logic [3:0] OP_SUB     = 4'd4;
  localparam logic [3:0] OP_XOR     = 4'd5;
  localparam logic [3:0] OP_CLR_ALL = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DST   = 3'd1,
    ST_SRC   = 3'd2,
    ST_IMM   = 3'd3,
    ST_SEND  = 3'd4,
    ST_CLEAR = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_XOR = 2'd2
  } alu_op_t;

  // Number of whole bytes in a register word
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_cmd_engine_alu.sv
`default_nettype none
// ============================================================================
// Module      : reg_cmd_alu
// Description : Combinational two-operand ALU (add / subtract / xor).
//               carry_out is the unsigned carry for ADD and the borrow
//               (a < b) for SUB; it is 0 for XOR and ignored by the caller.
// Ports       : a, b      [DATA_W] operands (a is the destination value)
//               op        operation select
//               result    [DATA_W] result modulo 2**DATA_W
//               carry_out carry / borrow
// Revision    : 1.0 - initial release
// ============================================================================
module reg_cmd_alu
  import reg_cmd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // One extra bit: for the difference it becomes 1 exactly when a < b
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result    = w_sum[DATA_W-1:0];
    carry_out = w_sum[DATA_W];
    case (op)
      ALU_SUB: begin
        result    = w_diff[DATA_W-1:0];
        carry_out = w_diff[DATA_W];
      end
      ALU_XOR: begin
        result    = a ^ b;
        carry_out = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : reg_cmd_engine
// Description : Register-file command processor driven by a byte stream.
//               Supports NOP, MOV_IMM, GET, ACC, SUB, XOR and CLR_ALL with
//               valid/ready handshakes on both byte streams.
// Ports       : clk, rst            clock, synchronous active-high reset
//               in_data/valid/ready command byte stream in
//               out_data/valid/ready readback byte stream out
//               busy                state is not IDLE
//               carry               carry/borrow of last ACC/SUB
//               err, err_clr        sticky illegal-opcode flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module reg_cmd_engine
  import reg_cmd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       carry,
  output logic       err,
  input  logic       err_clr
);

  localparam int NB       = bytes_per_word(DATA_W);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int BC_W     = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BC_W-1:0] c_LAST_BYTE = BC_W'(NB - 1);

  state_t            r_state;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [BC_W-1:0]   r_bcnt;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_stage;
  logic [DATA_W-1:0] r_shift;
  logic              r_out_valid;
  logic              r_carry;
  logic              r_err;

  logic              w_accept;
  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_carry;
  alu_op_t           w_alu_op;

  // Gated by rst so no byte is taken while reset is being applied
  assign in_ready  = !rst && (r_state inside {ST_IDLE, ST_DST, ST_SRC, ST_IMM});
  assign w_accept  = in_valid && in_ready;
  assign w_opcode  = in_data[3:0];
  assign w_addr    = in_data[ADDR_W-1:0];
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_shift[7:0];
  assign out_valid = r_out_valid;
  assign carry     = r_carry;
  assign err       = r_err;

  // Staging word with the incoming byte merged into its slot, so the final
  // immediate byte can be written to the file on the same edge it arrives
  always_comb begin
    w_imm = r_stage;
    for (int i = 0; i < NB; i++) begin
      if (int'(r_bcnt) == i) begin
        w_imm[i*8 +: 8] = in_data;
      end
    end
  end

  always_comb begin
    case (r_op)
      OP_SUB:  w_alu_op = ALU_SUB;
      OP_XOR:  w_alu_op = ALU_XOR;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  // Operands read combinationally: dst from the latched address, src from
  // the byte being accepted now
  reg_cmd_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a         (r_regs[r_dst]),
    .b         (r_regs[w_addr]),
    .op        (w_alu_op),
    .result    (w_alu_res),
    .carry_out (w_alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_dst       <= '0;
      r_clr_idx   <= '0;
      r_bcnt      <= '0;
      r_stage     <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      // A later set in the IDLE branch overrides this, so set wins
      if (err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= w_opcode;
            case (w_opcode)
              OP_NOP: ;
              OP_MOV_IMM, OP_ACC, OP_SUB, OP_XOR: r_state <= ST_DST;
              OP_GET: r_state <= ST_SRC;
              OP_CLR_ALL: begin
                r_state   <= ST_CLEAR;
                r_clr_idx <= '0;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        ST_DST: begin
          if (w_accept) begin
            r_dst   <= w_addr;
            r_bcnt  <= '0;
            r_state <= (r_op == OP_MOV_IMM) ? ST_IMM : ST_SRC;
          end
        end
        ST_IMM: begin
          if (w_accept) begin
            r_stage <= w_imm;
            if (r_bcnt == c_LAST_BYTE) begin
              r_regs[r_dst] <= w_imm;
              r_state       <= ST_IDLE;
            end else begin
              r_bcnt <= r_bcnt + BC_W'(1);
            end
          end
        end
        ST_SRC: begin
          if (w_accept) begin
            if (r_op == OP_GET) begin
              r_shift     <= r_regs[w_addr];
              r_out_valid <= 1'b1;
              r_bcnt      <= '0;
              r_state     <= ST_SEND;
            end else begin
              r_regs[r_dst] <= w_alu_res;
              if (r_op != OP_XOR) begin
                r_carry <= w_alu_carry;
              end
              r_state <= ST_IDLE;
            end
          end
        end
        ST_SEND: begin
          if (r_out_valid && out_ready) begin
            if (r_bcnt == c_LAST_BYTE) begin
              r_out_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_shift <= r_shift >> 8;
              r_bcnt  <= r_bcnt + BC_W'(1);
            end
          end
        end
        ST_CLEAR: begin
          r_regs[r_clr_idx] <= '0;
          r_carry           <= 1'b0;
          if (&r_clr_idx) begin
            r_state <= ST_IDLE;
          end else begin
            r_clr_idx <= r_clr_idx + ADDR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
